// File: rtl/fc_irq_ctrl_multi.sv
// fc_irq_ctrl_multi
//  Parametrised interrupt front-end for the FC core. Collects SoC event lines,
//  keeps a pending bit per line (edge or level mode), feeds one line from an
//  event-word FIFO, and presents the highest-index enabled pending line to the
//  core as a one-hot request plus its index.
//
// Ports
//  clk_i               clock
//  rst_i               synchronous active-high reset
//  events_i            raw irq lines (bit FIFO_IRQ_ID has no effect)
//  irq_mask_i          1 = line enabled
//  event_fifo_valid_i  FIFO push request
//  event_fifo_fulln_o  1 = FIFO can accept a push
//  event_fifo_data_i   FIFO push data
//  event_data_o        FIFO head word, 0 when empty
//  event_data_valid_o  FIFO not empty
//  irq_o               one-hot request to the core
//  irq_id_o            index of the asserted irq_o bit
//  irq_ack_i           core acknowledge, single-cycle pulse
//  irq_ack_id_i        id being acknowledged
//  wake_o              any enabled line pending
//
// FIFO push handshake: a word is taken on a clock edge where
// event_fifo_valid_i and event_fifo_fulln_o are both 1. fulln comes from the
// registered count only, so a pop in the same cycle never frees a slot for a
// push to a full FIFO. The producer may hold valid/data while fulln is 0.
//
// irq_o, irq_id_o and wake_o are registered: they are computed from the
// next-state pending vector and the current mask, so an edge sampled at clock
// edge N, an ack at edge N, or a mask change at edge N is all visible right
// after edge N, and the outputs have no combinational path from any input.

module fc_irq_ctrl_multi #(
  parameter int          NB_IRQ       = 32,
  parameter logic [31:0] EDGE_MASK    = 32'hFFFF_0000,
  parameter int          FIFO_IRQ_ID  = 26,
  parameter int          EVT_ID_WIDTH = 8,
  parameter int          FIFO_DEPTH   = 8,
  localparam int         ID_W         = $clog2(NB_IRQ),
  localparam int         PTR_W        = $clog2(FIFO_DEPTH),
  localparam int         CNT_W        = PTR_W + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NB_IRQ-1:0]       events_i,
  input  logic [NB_IRQ-1:0]       irq_mask_i,
  input  logic                    event_fifo_valid_i,
  output logic                    event_fifo_fulln_o,
  input  logic [EVT_ID_WIDTH-1:0] event_fifo_data_i,
  output logic [EVT_ID_WIDTH-1:0] event_data_o,
  output logic                    event_data_valid_o,
  output logic [NB_IRQ-1:0]       irq_o,
  output logic [ID_W-1:0]         irq_id_o,
  input  logic                    irq_ack_i,
  input  logic [4:0]              irq_ack_id_i,
  output logic                    wake_o
);

  localparam logic [NB_IRQ-1:0] EDGE_LINES = EDGE_MASK[NB_IRQ-1:0];
  localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FIFO_DEPTH);

  logic [NB_IRQ-1:0]       pending_q, pending_d;
  logic [NB_IRQ-1:0]       evt_q;
  logic [NB_IRQ-1:0]       rise;
  logic [NB_IRQ-1:0]       ack_hit;
  logic [NB_IRQ-1:0]       req_d;
  logic [NB_IRQ-1:0]       irq_d, irq_q;
  logic [ID_W-1:0]         id_d, irq_id_q;
  logic                    wake_q;

  logic [EVT_ID_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    push, pop;

  // Push is refused at full even if a pop happens in the same cycle.
  assign push = event_fifo_valid_i && (count_q != CNT_FULL);
  // Ack of the FIFO line while empty is ignored.
  assign pop  = irq_ack_i && (irq_ack_id_i == 5'(FIFO_IRQ_ID)) && (count_q != '0);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_comb begin
    rise    = events_i & ~evt_q;
    ack_hit = '0;
    // Ids >= NB_IRQ match no bit and are therefore ignored.
    for (int i = 0; i < NB_IRQ; i++) begin
      ack_hit[i] = irq_ack_i && (irq_ack_id_i == 5'(i));
    end
    // Edge lines: a new edge wins over a same-cycle ack.
    // Level lines: follow the source; ack has no effect.
    pending_d = (EDGE_LINES & (rise | (pending_q & ~ack_hit)))
              | (~EDGE_LINES & events_i);
    pending_d[FIFO_IRQ_ID] = (count_d != '0);
    req_d = pending_d & irq_mask_i;
    // Fixed priority: highest set index wins (later iterations override).
    irq_d = '0;
    id_d  = '0;
    for (int i = 0; i < NB_IRQ; i++) begin
      if (req_d[i]) begin
        irq_d = '0;
        irq_d[i] = 1'b1;
        id_d = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
      evt_q     <= '0;
      irq_q     <= '0;
      irq_id_q  <= '0;
      wake_q    <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      evt_q     <= events_i;
      irq_q     <= irq_d;
      irq_id_q  <= id_d;
      wake_q    <= |req_d;
      count_q   <= count_d;
      // Pointers wrap naturally: FIFO_DEPTH is a power of two.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the count gates every read.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) fifo_mem[wr_ptr_q] <= event_fifo_data_i;
  end

  assign irq_o              = irq_q;
  assign irq_id_o           = irq_id_q;
  assign wake_o             = wake_q;
  // pending_q[FIFO_IRQ_ID] is the registered "count != 0".
  assign event_data_valid_o = pending_q[FIFO_IRQ_ID];
  assign event_data_o       = event_data_valid_o ? fifo_mem[rd_ptr_q] : '0;
  assign event_fifo_fulln_o = (count_q != CNT_FULL);

endmodule

// File: tb/tb_fc_irq_ctrl_multi.sv
module tb_fc_irq_ctrl_multi;

  localparam int NB_IRQ = 32;
  localparam int DEPTH  = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NB_IRQ-1:0] events;
  logic [NB_IRQ-1:0] mask;
  logic              fifo_valid;
  logic              fifo_fulln;
  logic [7:0]        fifo_data;
  logic [7:0]        data_o;
  logic              data_valid;
  logic [NB_IRQ-1:0] irq;
  logic [4:0]        irq_id;
  logic              ack;
  logic [4:0]        ack_id;
  logic              wake;

  fc_irq_ctrl_multi dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .events_i           (events),
    .irq_mask_i         (mask),
    .event_fifo_valid_i (fifo_valid),
    .event_fifo_fulln_o (fifo_fulln),
    .event_fifo_data_i  (fifo_data),
    .event_data_o       (data_o),
    .event_data_valid_o (data_valid),
    .irq_o              (irq),
    .irq_id_o           (irq_id),
    .irq_ack_i          (ack),
    .irq_ack_id_i       (ack_id),
    .wake_o             (wake)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_irq"},   irq, 0);
    check({tag, "_id"},    32'(irq_id), 0);
    check({tag, "_wake"},  32'(wake), 0);
    check({tag, "_valid"}, 32'(data_valid), 0);
    check({tag, "_data"},  32'(data_o), 0);
    check({tag, "_fulln"}, 32'(fifo_fulln), 1);
  endtask

  task automatic expect_irq(input string tag, input int line);
    check({tag, "_irq"}, irq, 32'(1) << line);
    check({tag, "_id"},  32'(irq_id), 32'(line));
  endtask

  task automatic do_ack(input int line);
    ack = 1'b1; ack_id = 5'(line);
    step();
    ack = 1'b0;
  endtask

  // push a word; scoreboard records it only if the model says there is room
  task automatic push_word(input logic [7:0] w);
    fifo_valid = 1'b1; fifo_data = w;
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    step();
    fifo_valid = 1'b0;
  endtask

  // pop one entry via ack 26, comparing the head against the scoreboard first
  task automatic pop_check(input string tag);
    check({tag, "_valid"}, 32'(data_valid), 1);
    if (exp_q.size() > 0) check({tag, "_head"}, 32'(data_o), 32'(exp_q.pop_front()));
    do_ack(26);
  endtask

  initial begin
    rst = 1'b1; events = '0; mask = '1; fifo_valid = 1'b0; fifo_data = '0;
    ack = 1'b0; ack_id = '0;
    step(); step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // 1: edge line 20
    events[20] = 1'b1;
    step();
    events[20] = 1'b0;
    expect_irq("t1_set", 20);
    check("t1_wake", 32'(wake), 1);
    do_ack(20);
    check("t1_ack_irq", irq, 0);
    check("t1_ack_wake", 32'(wake), 0);

    // 2: level line 3 and edge line 20
    events[3] = 1'b1; events[20] = 1'b1;
    step();
    events[20] = 1'b0;
    expect_irq("t2_prio", 20);
    do_ack(20);
    expect_irq("t2_next", 3);
    do_ack(3);  // ack on a level line has no effect
    expect_irq("t2_level_hold", 3);
    events[3] = 1'b0;
    step();
    check("t2_drop", irq, 0);

    // 3: fill, overfill, drain
    for (int k = 0; k < DEPTH; k++) push_word(8'h10 + 8'(k));
    check("t3_full", 32'(fifo_fulln), 0);
    expect_irq("t3_line26", 26);
    push_word(8'h99);
    check("t3_refused_fulln", 32'(fifo_fulln), 0);
    check("t3_refused_head", 32'(data_o), 32'h10);
    while (exp_q.size() > 0) pop_check("t3_pop");
    check("t3_empty_valid", 32'(data_valid), 0);
    check("t3_empty_irq", irq, 0);
    check("t3_empty_data", 32'(data_o), 0);
    do_ack(26);  // ack on empty FIFO is ignored
    check("t3_empty_ack_fulln", 32'(fifo_fulln), 1);

    // 4: push+pop at count 4, then at full
    for (int k = 0; k < 4; k++) push_word(8'h20 + 8'(k));
    fifo_valid = 1'b1; fifo_data = 8'h24; ack = 1'b1; ack_id = 5'd26;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h24);
    step();
    fifo_valid = 1'b0; ack = 1'b0;
    check("t4_mid_head", 32'(data_o), 32'(exp_q[0]));
    check("t4_mid_fulln", 32'(fifo_fulln), 1);
    for (int k = 0; k < 4; k++) push_word(8'h25 + 8'(k));
    check("t4_full", 32'(fifo_fulln), 0);
    fifo_valid = 1'b1; fifo_data = 8'h77; ack = 1'b1; ack_id = 5'd26;
    void'(exp_q.pop_front());  // pop succeeds, push refused
    step();
    fifo_valid = 1'b0; ack = 1'b0;
    check("t4_full_pop_fulln", 32'(fifo_fulln), 1);
    while (exp_q.size() > 0) pop_check("t4_drain");
    check("t4_drain_valid", 32'(data_valid), 0);

    // random push/pop traffic against the scoreboard
    for (int c = 0; c < 80; c++) begin
      logic do_push, do_pop;
      do_push = ($urandom_range(0, 2) != 0);
      do_pop  = ($urandom_range(0, 2) == 0);
      check("rnd_fulln", 32'(fifo_fulln), 32'(exp_q.size() != DEPTH));
      check("rnd_valid", 32'(data_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) check("rnd_head", 32'(data_o), 32'(exp_q[0]));
      fifo_valid = do_push; fifo_data = 8'($urandom_range(0, 255));
      ack = do_pop; ack_id = 5'd26;
      if (do_pop && exp_q.size() != 0) begin
        if (do_push && exp_q.size() != DEPTH) exp_q.push_back(fifo_data);
        void'(exp_q.pop_front());
      end else if (do_push && exp_q.size() != DEPTH) begin
        exp_q.push_back(fifo_data);
      end
      step();
    end
    fifo_valid = 1'b0; ack = 1'b0;
    while (exp_q.size() > 0) pop_check("rnd_drain");

    // 5: new edge coinciding with ack
    events[20] = 1'b1;
    step();
    events[20] = 1'b0;
    step();
    events[20] = 1'b1; ack = 1'b1; ack_id = 5'd20;
    step();
    events[20] = 1'b0; ack = 1'b0;
    expect_irq("t5_set_wins", 20);
    do_ack(21);  // line 21 not pending: ignored
    expect_irq("t5_other_ack", 20);
    do_ack(20);
    check("t5_clear", irq, 0);

    // 6: masking, then reset with FIFO contents
    events[20] = 1'b1;
    step();
    events[20] = 1'b0;
    mask[20] = 1'b0;
    step();
    check("t6_masked_irq", irq, 0);
    check("t6_masked_wake", 32'(wake), 0);
    mask[20] = 1'b1;
    step();
    expect_irq("t6_unmask", 20);
    for (int k = 0; k < 3; k++) push_word(8'($urandom_range(0, 255)));
    events[3] = 1'b1;
    rst = 1'b1;
    step();
    exp_q.delete();
    check_reset_outputs("t6_rst");
    rst = 1'b0; events = '0;
    step();
    check("t6_after_rst_irq", irq, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
